// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner: matrix geometry,
// scan-result encoding, debounce FSM states and small bit-counting helpers.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Scan result is {none_flag, code}; the flag set means "no single key".
    localparam logic [KEY_W:0] NO_KEY = {1'b1, {KEY_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Number of set bits, saturated at 2 (only 0 / 1 / many matters).
    function automatic logic [1:0] hits_sat(input logic [COLS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest set bit (meaningful only when exactly one bit is set).
    function automatic logic [COL_W-1:0] low_idx(input logic [COLS-1:0] v);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous column inputs. Resets to
// all-ones so an idle (pulled-up) matrix reads as "no key" from the start.
module sync_2ff
    import keypad_pkg::*;
#(
    parameter int W = COLS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops; only r_sync is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: drives one row at a time, accumulates a full-scan
// result, debounces it over several scans and hands one key code per press
// to the consumer, held until acknowledged.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] col_sense,
    output logic [3:0] row_drive,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS);

    // Synchronised, active-high column hits
    logic [COLS-1:0]  w_cols;
    logic [COLS-1:0]  w_col_act;

    // Scan timer
    logic [ROW_W-1:0] r_row;
    logic [DW-1:0]    r_dwell;
    logic [ROWS-1:0]  r_row_drive;
    logic             w_sample;
    logic             w_scan_end;
    logic [ROW_W-1:0] w_row_next;

    // Per-scan accumulator
    logic [1:0]       r_hits;
    logic [KEY_W-1:0] r_cand;
    logic [1:0]       w_row_hits;
    logic [COL_W-1:0] w_row_col;
    logic [2:0]       w_tot_sum;
    logic [1:0]       w_tot;
    logic [KEY_W-1:0] w_tot_cand;
    logic [KEY_W:0]   w_scan_res;
    logic             w_res_none;
    logic [KEY_W-1:0] w_res_code;

    // Debounce FSM
    kp_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [KEY_W-1:0] r_code_q;
    logic             r_held;
    logic             w_event;
    logic [KEY_W-1:0] w_event_code;

    // Output register
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

    sync_2ff #(.W(COLS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (col_sense),
        .o_q   (w_cols)
    );

    assign w_col_act  = ~w_cols;
    assign w_sample   = ena && (r_dwell == DWELL_LAST);
    assign w_scan_end = w_sample && (r_row == ROW_W'(ROWS - 1));
    assign w_row_next = w_sample ? r_row + ROW_W'(1) : r_row;

    // Row dwell timer; row_drive follows the row it is about to scan so the
    // strobe and the row index change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_dwell     <= '0;
            r_row_drive <= '1;
        end else if (!ena) begin
            r_row       <= '0;
            r_dwell     <= '0;
            r_row_drive <= '1;
        end else begin
            r_dwell     <= w_sample ? '0 : r_dwell + DW'(1);
            r_row       <= w_row_next;
            r_row_drive <= ~(ROWS'(1) << w_row_next);
        end
    end

    assign w_row_hits = hits_sat(w_col_act);
    assign w_row_col  = low_idx(w_col_act);
    assign w_tot_sum  = {1'b0, r_hits} + {1'b0, w_row_hits};
    assign w_tot      = (w_tot_sum >= 3'd2) ? 2'd2 : w_tot_sum[1:0];
    assign w_tot_cand = (w_row_hits == 2'd1) ? {r_row, w_row_col} : r_cand;
    assign w_scan_res = (w_tot == 2'd1) ? {1'b0, w_tot_cand} : NO_KEY;
    assign w_res_none = w_scan_res[KEY_W];
    assign w_res_code = w_scan_res[KEY_W-1:0];
    assign w_cnt_inc  = r_cnt + CNT_ONE;

    // Accumulate key hits across rows; the total is consumed at the row-3 sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= '0;
            r_cand <= '0;
        end else if (!ena) begin
            r_hits <= '0;
            r_cand <= '0;
        end else if (w_sample) begin
            if (w_scan_end) begin
                r_hits <= '0;
                r_cand <= '0;
            end else begin
                r_hits <= w_tot;
                r_cand <= w_tot_cand;
            end
        end
    end

    // A new press event fires only when a debounce run completes; returning
    // from RELEASE to PRESSED is the same press and stays silent.
    always_comb begin
        w_event      = 1'b0;
        w_event_code = r_code_q;
        if (w_scan_end && !w_res_none) begin
            case (r_state)
                IDLE: begin
                    if (DEBOUNCE_SCANS == 1) begin
                        w_event      = 1'b1;
                        w_event_code = w_res_code;
                    end
                end
                DEBOUNCE: begin
                    if ((w_res_code == r_code_q) && (w_cnt_inc == CNT_LAST)) begin
                        w_event = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Debounce FSM, stepped once per completed scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_code_q <= '0;
            r_held   <= 1'b0;
        end else if (!ena) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_code_q <= '0;
            r_held   <= 1'b0;
        end else if (w_scan_end) begin
            case (r_state)
                IDLE: begin
                    if (!w_res_none) begin
                        r_code_q <= w_res_code;
                        if (w_event) begin
                            r_state <= PRESSED;
                            r_cnt   <= '0;
                            r_held  <= 1'b1;
                        end else begin
                            r_state <= DEBOUNCE;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_res_none || (w_res_code != r_code_q)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_event) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (w_res_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_held  <= 1'b0;
                        end else begin
                            r_state <= RELEASE;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!w_res_none) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == CNT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    // Consumer handshake: load on event, drop (and flag) if the previous key
    // is still unacknowledged, clear on ack. Runs regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_event) begin
            if (!r_key_valid || key_ack) begin
                r_key_code  <= w_event_code;
                r_key_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign row_drive = r_row_drive;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_held;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a key matrix driven from row_drive, a
// scan-level vector table, hand-timed corner cases, and random presses
// checked against a scan-level reference model.
module tb_keypad_matrix_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        key_ack = 1'b0;
    logic [3:0]  col_sense;
    logic [3:0]  row_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed = '0;
    logic [3:0]  last_rd = 4'b1111;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] mask;
        bit          ack;
        bit          v;
        logic [3:0]  code;
        bit          h;
        bit          o;
    } vec_t;

    vec_t tbl[$];

    // reference model state (scan granularity)
    bit         m_valid, m_held, m_ovr;
    logic [3:0] m_code, m_key;
    int         m_streak, m_rel;

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .col_sense (col_sense),
        .row_drive (row_drive),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to a driven (low) row.
    always_comb begin
        col_sense = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row_drive[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) col_sense[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) last_rd <= row_drive;

    function automatic logic [15:0] K(input int k);
        return 16'(1) << k;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit v, input logic [3:0] c, input bit h, input bit o);
        check({tag, "_valid"}, 16'(key_valid), 16'(v));
        check({tag, "_code"},  16'(key_code),  16'(c));
        check({tag, "_held"},  16'(key_held),  16'(h));
        check({tag, "_ovr"},   16'(overrun),   16'(o));
    endtask

    // Returns at the negedge right after row 0 becomes driven (scan start).
    task automatic wait_scan_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (row_drive == 4'b1110 && last_rd != 4'b1110) seen = 1'b1;
        end
        check("scan_start_timeout", 16'(seen), 16'(1));
    endtask

    task automatic ack_pulse();
        repeat (4) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic add(input int n, input logic [15:0] m, input bit a, input bit v,
                       input int c, input bit h, input bit o);
        vec_t e;
        e.mask = m; e.ack = a; e.v = v; e.code = 4'(c); e.h = h; e.o = o;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // One completed scan: a single key anywhere in the matrix is a candidate,
    // anything else is "none"; presses and releases need DB identical scans.
    task automatic model_scan(input logic [15:0] pat);
        bit         none;
        logic [3:0] res;
        none = ($countones(pat) != 1);
        res  = '0;
        for (int k = 0; k < 16; k++) if (pat[k]) res = 4'(k);
        if (!m_held) begin
            if (none) m_streak = 0;
            else if (m_streak != 0 && res != m_key) m_streak = 0;
            else begin
                if (m_streak == 0) m_key = res;
                m_streak++;
            end
            if (m_streak == DB) begin
                m_held = 1'b1; m_streak = 0; m_rel = 0;
                if (!m_valid) begin
                    m_valid = 1'b1; m_code = m_key;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end else begin
            if (none) begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 1'b0; m_rel = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    initial begin
        logic [15:0] pat;
        int          rem;
        int          kind, k1, k2;
        bit          do_ack;

        // ---------------- reset state
        repeat (3) @(negedge clk);
        check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        check("reset_rowdrv", 16'(row_drive), 16'hF);
        rst_n = 1'b1;

        // ---------------- scan-level vector table (outputs seen after each scan)
        // press 9 for 10 scans, release, ack
        add(2, K(9), 0, 0, 0, 0, 0);
        add(8, K(9), 0, 1, 9, 1, 0);
        add(2, '0,   0, 1, 9, 1, 0);
        add(1, '0,   0, 1, 9, 0, 0);
        add(1, '0,   1, 0, 9, 0, 0);
        // bouncing 0 then stable
        add(1, K(0), 0, 0, 9, 0, 0);
        add(1, '0,   0, 0, 9, 0, 0);
        add(1, K(0), 0, 0, 9, 0, 0);
        add(1, '0,   0, 0, 9, 0, 0);
        add(2, K(0), 0, 0, 9, 0, 0);
        add(1, K(0), 0, 1, 0, 1, 0);
        add(2, '0,   0, 1, 0, 1, 0);
        add(1, '0,   0, 1, 0, 0, 0);
        add(1, '0,   1, 0, 0, 0, 0);
        // bounce alone: two scans only
        add(2, K(0), 0, 0, 0, 0, 0);
        add(2, '0,   0, 0, 0, 0, 0);
        // ghosting: same row, then different rows, then 5 alone
        add(4, K(5) | K(6),  0, 0, 0, 0, 0);
        add(3, K(1) | K(14), 0, 0, 0, 0, 0);
        add(2, K(5), 0, 0, 0, 0, 0);
        add(1, K(5), 0, 1, 5, 1, 0);
        add(2, '0,   0, 1, 5, 1, 0);
        add(1, '0,   0, 1, 5, 0, 0);
        add(1, '0,   1, 0, 5, 0, 0);
        // press 3 unacked, then 12 -> overrun, then ack
        add(2, K(3),  0, 0, 5, 0, 0);
        add(1, K(3),  0, 1, 3, 1, 0);
        add(2, '0,    0, 1, 3, 1, 0);
        add(1, '0,    0, 1, 3, 0, 0);
        add(2, K(12), 0, 1, 3, 0, 0);
        add(1, K(12), 0, 1, 3, 1, 1);
        add(2, '0,    0, 1, 3, 1, 1);
        add(1, '0,    0, 1, 3, 0, 1);
        add(1, '0,    1, 0, 3, 0, 0);
        // press 7 and leave it unacknowledged
        add(2, K(7), 0, 0, 3, 0, 0);
        add(1, K(7), 0, 1, 7, 1, 0);
        add(2, '0,   0, 1, 7, 1, 0);
        add(1, '0,   0, 1, 7, 0, 0);

        wait_scan_start();
        foreach (tbl[i]) begin
            pressed = tbl[i].mask;
            if (tbl[i].ack) ack_pulse();
            wait_scan_start();
            check_outs($sformatf("t%0d", i), tbl[i].v, tbl[i].code, tbl[i].h, tbl[i].o);
        end

        // ---------------- ack in the same cycle as a new event
        pressed = K(10);
        wait_scan_start();
        wait_scan_start();
        repeat (15) @(negedge clk);
        check_outs("ack_evt_before", 1'b1, 4'd7, 1'b0, 1'b0);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check_outs("ack_evt_after", 1'b1, 4'd10, 1'b1, 1'b0);

        // ---------------- async reset in the middle of a debounce
        pressed = '0;
        repeat (4) wait_scan_start();
        pressed = K(2);
        repeat (2) wait_scan_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 1'b0, 4'd0, 1'b0, 1'b0);
        check("rst_mid_rowdrv", 16'(row_drive), 16'hF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_scan_start();
        repeat (2) wait_scan_start();
        check("rst_no_partial_evt", 16'(key_valid), 16'(0));
        pressed = '0;
        wait_scan_start();
        check_outs("rst_after", 1'b0, 4'd0, 1'b0, 1'b0);

        // ---------------- ena dropped mid-scan
        pressed = K(4);
        repeat (3) wait_scan_start();
        check_outs("ena_pre", 1'b1, 4'd4, 1'b1, 1'b0);
        pressed = K(8);
        wait_scan_start();
        repeat (6) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ena_off_rowdrv", 16'(row_drive), 16'hF);
        check_outs("ena_off", 1'b1, 4'd4, 1'b0, 1'b0);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check_outs("ena_off_ack", 1'b0, 4'd4, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("ena_off_rowdrv2", 16'(row_drive), 16'hF);
        ena = 1'b1;
        wait_scan_start();
        repeat (2) wait_scan_start();
        check("ena_restart_noevt", 16'(key_valid), 16'(0));
        wait_scan_start();
        check_outs("ena_restart_evt", 1'b1, 4'd8, 1'b1, 1'b0);

        // ---------------- random presses vs. reference model
        @(negedge clk);
        rst_n   = 1'b0;
        pressed = '0;
        m_valid = 0; m_held = 0; m_ovr = 0; m_code = '0; m_key = '0;
        m_streak = 0; m_rel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_scan_start();
        rem = 0;
        pat = '0;
        for (int s = 0; s < 160; s++) begin
            if (rem == 0) begin
                rem  = int'($urandom_range(1, 5));
                kind = int'($urandom_range(0, 9));
                k1   = int'($urandom_range(0, 15));
                k2   = (k1 + int'($urandom_range(1, 15))) % 16;
                if (kind <= 2)      pat = '0;
                else if (kind <= 8) pat = K(k1);
                else                pat = K(k1) | K(k2);
            end
            rem--;
            pressed = pat;
            do_ack  = ($urandom_range(0, 3) == 0);
            if (do_ack) begin
                ack_pulse();
                model_ack();
            end
            wait_scan_start();
            model_scan(pat);
            check_outs($sformatf("rnd%0d", s), m_valid, m_code, m_held, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
